// File: rtl/top_level.sv
// Pattern-count engine: scans a 256-bit message in data memory for a 5-bit pattern
// and writes in-byte, per-byte and whole-string match counts back to memory.

module top_level_dmem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] core [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) core[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = core[i_rd_addr];
endmodule

module top_level (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);
    typedef enum logic [2:0] {IDLE, LOADP, SCAN, WR33, WR34, WR35, DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_j;
    logic [4:0]  r_p;
    logic [3:0]  r_prev_lo;
    logic [7:0]  r_ctb;
    logic [7:0]  r_cto;
    logic [7:0]  r_cts;

    logic        w_wr_en;
    logic [7:0]  w_wr_addr;
    logic [7:0]  w_wr_data;
    logic [7:0]  w_rd_addr;
    logic [7:0]  w_byte;
    logic [2:0]  w_in;
    logic [2:0]  w_x;

    // Counts the four 5-bit windows of an 8-bit value that equal the pattern.
    function automatic logic [2:0] f_win_hits(input logic [7:0] b, input logic [4:0] p);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (b[k+:5] == p) cnt = cnt + 3'd1;
        end
        return cnt;
    endfunction

    top_level_dmem #(.DATA_W(8), .ADDR_W(8)) dm1 (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_byte)
    );

    assign w_rd_addr = (r_state == LOADP) ? 8'd32 : {3'd0, r_j};
    assign w_in      = f_win_hits(w_byte, r_p);
    // Crossing windows span the low nibble of the previous byte and high nibble of this one.
    assign w_x       = (r_j != 5'd0) ? f_win_hits({r_prev_lo, w_byte[7:4]}, r_p) : 3'd0;

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = 8'd0;
        w_wr_data = 8'd0;
        case (r_state)
            WR33: begin w_wr_en = 1'b1; w_wr_addr = 8'd33; w_wr_data = r_ctb; end
            WR34: begin w_wr_en = 1'b1; w_wr_addr = 8'd34; w_wr_data = r_cto; end
            WR35: begin w_wr_en = 1'b1; w_wr_addr = 8'd35; w_wr_data = r_cts; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_j       <= 5'd0;
            r_p       <= 5'd0;
            r_prev_lo <= 4'd0;
            r_ctb     <= 8'd0;
            r_cto     <= 8'd0;
            r_cts     <= 8'd0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= LOADP;
                        r_ctb   <= 8'd0;
                        r_cto   <= 8'd0;
                        r_cts   <= 8'd0;
                        done    <= 1'b0;
                    end
                end
                LOADP: begin
                    r_p     <= w_byte[7:3];
                    r_j     <= 5'd0;
                    r_state <= SCAN;
                end
                SCAN: begin
                    r_ctb     <= r_ctb + {5'd0, w_in};
                    r_cto     <= r_cto + {7'd0, (w_in != 3'd0)};
                    r_cts     <= r_cts + {5'd0, w_in} + {5'd0, w_x};
                    r_prev_lo <= w_byte[3:0];
                    r_j       <= r_j + 5'd1;
                    if (r_j == 5'd31) r_state <= WR33;
                end
                WR33: r_state <= WR34;
                WR34: r_state <= WR35;
                WR35: begin
                    r_state <= DONE;
                    done    <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_top_level.sv
// Randomized and directed bench for top_level: checks done timing every cycle and
// the written counts against a whole-string reference model.

module tb_top_level;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic done;

    int vectors = 0;
    int errors = 0;

    logic [7:0] img [0:255];

    logic m_busy;
    int   m_cnt;
    logic m_done;
    logic chk_en = 1'b0;

    top_level dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Timing reference: a run accepted while idle completes 36 edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_done <= 1'b0;
            end
        end else if (m_cnt == 35) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (done !== m_done) begin
                errors++;
                $display("FAIL done_cycle t=%0t got %b want %b", $time, done, m_done);
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Counts over the 256-bit string: windows inside one byte give ctb, all give cts.
    task automatic model_calc(output logic [7:0] ctb, output logic [7:0] cto, output logic [7:0] cts);
        logic [255:0] s;
        logic [31:0]  byte_hit;
        logic [4:0]   p;
        p = img[32][7:3];
        for (int i = 0; i < 32; i++) s[255-8*i -: 8] = img[i];
        byte_hit = 32'd0;
        ctb = 8'd0;
        cto = 8'd0;
        cts = 8'd0;
        for (int k = 0; k < 252; k++) begin
            if (s[k+:5] == p) begin
                cts = cts + 8'd1;
                if ((k / 8) == ((k + 4) / 8)) begin
                    ctb = ctb + 8'd1;
                    byte_hit[k/8] = 1'b1;
                end
            end
        end
        for (int b = 0; b < 32; b++) if (byte_hit[b]) cto = cto + 8'd1;
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++) dut.dm1.core[i] = img[i];
    endtask

    task automatic fill(input logic [7:0] v, input logic [7:0] pbyte);
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 32; i++) img[i] = v;
        img[32] = pbyte;
    endtask

    task automatic do_run(input bit use_lit, input logic [7:0] l_ctb, input logic [7:0] l_cto,
                          input logic [7:0] l_cts, input bit mid_start, input string tag);
        logic [7:0] e_ctb, e_cto, e_cts;
        int n;
        int bad;
        model_calc(e_ctb, e_cto, e_cts);
        if (use_lit) begin
            check8({tag, "_model_ctb"}, e_ctb, l_ctb);
            check8({tag, "_model_cto"}, e_cto, l_cto);
            check8({tag, "_model_cts"}, e_cts, l_cts);
        end
        preload();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            start = (mid_start && n == 10) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        vectors++;
        if (n != 36) begin
            errors++;
            $display("FAIL %s_latency got %0d want 36", tag, n);
        end
        check8({tag, "_ctb"}, dut.dm1.core[33], e_ctb);
        check8({tag, "_cto"}, dut.dm1.core[34], e_cto);
        check8({tag, "_cts"}, dut.dm1.core[35], e_cts);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (i < 33 || i > 35) if (dut.dm1.core[i] !== img[i]) bad++;
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_other_addrs got %0d changed want 0", tag, bad);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] pool [0:5];
        logic [4:0] p;
        pool[0] = 8'h00; pool[1] = 8'hFF; pool[2] = 8'h55;
        pool[3] = 8'hF8; pool[4] = 8'h1F; pool[5] = 8'h3E;

        repeat (3) @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", done);
        end
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        fill(8'h00, 8'h00);
        do_run(1'b1, 8'd128, 8'd32, 8'd252, 1'b0, "zeros");
        fill(8'h55, 8'hA8);
        do_run(1'b1, 8'd64, 8'd32, 8'd126, 1'b0, "alt55");
        fill(8'hFF, 8'h07);
        do_run(1'b1, 8'd0, 8'd0, 8'd0, 1'b0, "ones_p0");
        fill(8'h00, 8'hF8);
        img[0] = 8'h0F;
        img[1] = 8'h80;
        do_run(1'b1, 8'd0, 8'd0, 8'd1, 1'b0, "cross");

        // Abort a run mid-scan; sentinels in the result slots must survive.
        fill(8'hFF, 8'hF8);
        img[33] = 8'hA5; img[34] = 8'hA5; img[35] = 8'hA5;
        preload();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_done got %b want 0", done);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check8("abort_core33", dut.dm1.core[33], 8'hA5);
        check8("abort_core34", dut.dm1.core[34], 8'hA5);
        check8("abort_core35", dut.dm1.core[35], 8'hA5);
        do_run(1'b1, 8'd128, 8'd32, 8'd252, 1'b0, "after_reset");

        fill(8'h00, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 32; i++) img[i] = 8'($urandom_range(0, 255));
        do_run(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, "start_in_scan");

        for (int r = 0; r < 20; r++) begin
            p = 5'($urandom_range(0, 31));
            fill(8'h00, {p, 3'($urandom_range(0, 7))});
            for (int i = 0; i < 32; i++)
                img[i] = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)]
                                                     : 8'($urandom_range(0, 255));
            do_run(1'b0, 8'd0, 8'd0, 8'd0, (r % 4) == 1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
